// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg
// Shared types and helpers for the dot-product MAC sequencer.
//   state_t   : sequencer FSM states
//   tag_t     : per-term marker carried alongside the BRAM/DSP pipeline
//   OUT_MAX   : saturation ceiling of the 16-bit result
//   ACC_W_MAX : widest accumulator the saturation helper accepts
//   sat16     : clamps a zero-extended sum to 16 bits

package mac_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // valid marks a real term in flight, last marks the final term of a request.
   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   localparam logic [15:0] OUT_MAX   = 16'hFFFF;
   localparam int          ACC_W_MAX = 32;

   // Callers zero-extend their accumulator (ACC_W bits) to ACC_W_MAX before calling.
   // Any set bit above bit 15 means the sum no longer fits, so clamp to OUT_MAX.
   function automatic logic [15:0] sat16(input logic [ACC_W_MAX-1:0] sum);
      if (|sum[ACC_W_MAX-1:16]) begin
         return OUT_MAX;
      end
      return sum[15:0];
   endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// mac_tag_pipe
// D-stage shift register of tags that travels in lock-step with the BRAM read,
// the operand register and the DSP pipeline, so the sequencer knows exactly
// when operand data is valid and when a product appears on P.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset, clears every stage
//   tagIn_i     : tag entering stage 0 (one per issued read)
//   dataValid_o : valid bit of stage DATA_STAGE (BRAM data present this cycle)
//   exitTag_o   : tag in the final stage (its product is on P this cycle)

module mac_tag_pipe
   import mac_seq_pkg::*;
#(
   parameter int D          = 5,
   parameter int DATA_STAGE = 0
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tagIn_i,
   output logic dataValid_o,
   output tag_t exitTag_o
);

   tag_t [D-1:0] pipe_q;

   // Plain shift: stage 0 takes the new tag, every other stage takes its
   // predecessor. Clearing on reset drops any request that was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= tagIn_i;
         for (int i = 1; i < D; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign dataValid_o = pipe_q[DATA_STAGE].valid;
   assign exitTag_o   = pipe_q[D-1];

endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq
// Sequences the shared 8x8 DSP MAC macro to compute one unsigned dot product
// plus bias per request. Activation/weight pairs are read from two single-port
// BRAMs at base+k (wrapping), registered into the DSP A/B inputs, and the P
// output is accumulated as each term's tag leaves the tag pipe. The result is
// saturated to 16 bits and returned over a valid/ready handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request pulse, only looked at in IDLE
//   len                 : number of terms N (0..2^ADDR_W)
//   act_base, wgt_base  : BRAM base addresses
//   bias                : unsigned bias added to the sum
//   busy                : high whenever not IDLE
//   rd_en               : read enable for both BRAMs
//   act_addr, wgt_addr  : BRAM read addresses
//   act_data, wgt_data  : BRAM read data (registered output)
//   mac_a, mac_b        : DSP A/B operands
//   mac_c, mac_carryin  : DSP C/CARRYIN, tied to zero so P = A*B
//   mac_p               : DSP P result
//   out_valid, out_ready: result handshake
//   out_data            : saturated 16-bit result

module mac_dot_seq
   import mac_seq_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int ACC_W       = 24,
   parameter int MAC_LATENCY = 3,
   parameter int RD_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic [ADDR_W-1:0] act_base,
   input  logic [ADDR_W-1:0] wgt_base,
   input  logic [15:0]       bias,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] act_addr,
   output logic [ADDR_W-1:0] wgt_addr,
   input  logic [7:0]        act_data,
   input  logic [7:0]        wgt_data,
   output logic [7:0]        mac_a,
   output logic [7:0]        mac_b,
   output logic [15:0]       mac_c,
   output logic              mac_carryin,
   input  logic [15:0]       mac_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data
);

   // Tag pipe depth: BRAM read, operand register, then the DSP stages.
   // ACC_W must be at least 16+ADDR_W (no accumulator wrap) and at most
   // ACC_W_MAX (width taken by sat16).
   localparam int D          = RD_LATENCY + 1 + MAC_LATENCY;
   localparam int DATA_STAGE = RD_LATENCY - 1;

   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W:0]     len_q, cnt_q;
   logic [ADDR_W-1:0]   actAddr_q, wgtAddr_q;
   logic [15:0]         bias_q, outData_q;
   logic [7:0]          macA_q, macB_q;
   logic [ACC_W-1:0]    acc_q, accNext;
   logic                settled_q;
   logic [ACC_W_MAX-1:0] sumWide;

   logic                startAccept, issueLast, lastExit;
   logic                busyInt, rdEnInt, outValid;
   logic                dataValid;
   tag_t                tagIn, exitTag;

   // A request is taken only in IDLE; start in any other state is ignored.
   assign startAccept = (state_q == IDLE) && start;

   // The issue cycle whose term index is N-1 is the last read of the request.
   assign issueLast = (state_q == ISSUE) && ((cnt_q + CNT_ONE) == len_q);

   // The final term's product is on P this cycle.
   assign lastExit = exitTag.valid && exitTag.last;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic. A zero-length request skips straight to DONE with
   // the bias as its result; otherwise we issue N reads, drain the pipe until
   // the last product is absorbed, and hold the result until it is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (issueLast) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (lastExit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (outValid && out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. out_valid waits one cycle after entering DONE (settled_q)
   // so the result register is presented with registered timing.
   always_comb begin
      busyInt  = (state_q != IDLE);
      rdEnInt  = (state_q == ISSUE);
      outValid = (state_q == DONE) && settled_q;
   end

   // Every issued read launches a tag; the last read carries the last flag.
   always_comb begin
      tagIn       = '0;
      tagIn.valid = rdEnInt;
      tagIn.last  = issueLast;
   end

   mac_tag_pipe #(
      .D          (D),
      .DATA_STAGE (DATA_STAGE)
   ) u_tagPipe (
      .clk         (clk),
      .rst         (rst),
      .tagIn_i     (tagIn),
      .dataValid_o (dataValid),
      .exitTag_o   (exitTag)
   );

   // Request registers, term counter and read addresses. Addresses advance
   // once per issued read and wrap naturally at 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= '0;
         bias_q    <= '0;
         cnt_q     <= '0;
         actAddr_q <= '0;
         wgtAddr_q <= '0;
      end else if (startAccept) begin
         len_q     <= len;
         bias_q    <= bias;
         cnt_q     <= '0;
         actAddr_q <= act_base;
         wgtAddr_q <= wgt_base;
      end else if (rdEnInt) begin
         cnt_q     <= cnt_q + CNT_ONE;
         actAddr_q <= actAddr_q + ADDR_ONE;
         wgtAddr_q <= wgtAddr_q + ADDR_ONE;
      end
   end

   // Operand registers feeding DSP A/B. They capture BRAM data only while a
   // valid term sits at the data stage and otherwise return to zero, so the
   // DSP sees quiet inputs between requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         macA_q <= '0;
         macB_q <= '0;
      end else if (dataValid) begin
         macA_q <= act_data;
         macB_q <= wgt_data;
      end else begin
         macA_q <= '0;
         macB_q <= '0;
      end
   end

   // P is only meaningful when a valid tag is leaving the pipe.
   always_comb begin
      accNext = acc_q;
      if (exitTag.valid) begin
         accNext = acc_q + {{(ACC_W-16){1'b0}}, mac_p};
      end
   end

   // Accumulator: cleared at request accept, absorbs each product as it exits.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else if (startAccept) begin
         acc_q <= '0;
      end else begin
         acc_q <= accNext;
      end
   end

   // Sum including the product exiting this cycle, so the result can be
   // captured on the same edge the last product is absorbed.
   assign sumWide = ACC_W_MAX'(accNext) + ACC_W_MAX'(bias_q);

   // Result register and the one-cycle settle flag behind out_valid. The
   // result is held unchanged for as long as the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         outData_q <= '0;
         settled_q <= 1'b0;
      end else begin
         settled_q <= (state_q == DONE) && (state_d == DONE);
         if (startAccept && (len == '0)) begin
            outData_q <= bias;
         end else if ((state_q == DRAIN) && lastExit) begin
            outData_q <= sat16(sumWide);
         end
      end
   end

   assign busy        = busyInt;
   assign rd_en       = rdEnInt;
   assign act_addr    = actAddr_q;
   assign wgt_addr    = wgtAddr_q;
   assign mac_a       = macA_q;
   assign mac_b       = macB_q;
   assign mac_c       = 16'h0000;
   assign mac_carryin = 1'b0;
   assign out_valid   = outValid;
   assign out_data    = outData_q;

endmodule
